// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter slice.
// Holds the arbiter state encoding, the requester port indices used to
// index the one-hot grant vector, and the width of the latency counter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_e;

  localparam int PORT_CPU = 0;
  localparam int PORT_DBG = 1;

  // Wide enough for the largest supported memory latency (15).
  localparam int CNT_W = 4;

endpackage

// File: rtl/load_reg.sv
// Loadable register with asynchronous active-high reset to zero.
// Ports:
//   clk_i   - clock
//   reset_i - asynchronous, active-high reset
//   load_i  - when high, d_i is captured on the rising clock edge
//   d_i     - data to capture
//   q_o     - registered value, held while load_i is low
module load_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  // Capture on load, otherwise hold the previous value.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      q_o <= '0;
    end else if (load_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker.
// Ports:
//   req_i        - request vector, bit 0 = CPU, bit 1 = debug port
//   last_grant_i - index of the port that won the previous grant
//   pick_o       - one-hot winner, 00 when nobody requests
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] pick_o
);

  // A lone requester always wins; on contention the port that did not win
  // last time goes first, so a losing port is served on the next grant.
  always_comb begin
    pick_o = 2'b00;
    case (req_i)
      2'b01:   pick_o = 2'b01;
      2'b10:   pick_o = 2'b10;
      2'b11: begin
        pick_o[PORT_CPU] = last_grant_i;
        pick_o[PORT_DBG] = ~last_grant_i;
      end
      default: pick_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing the single-port program/data memory between the CPU
// (port 0, cpu_*) and the debug/program-loader port (port 1, dbg_*).
// Each access walks IDLE -> ISSUE -> WAIT (MEM_LATENCY cycles) -> DONE and
// returns a one-cycle ack with the captured read data to the granted port.
// Ports:
//   clk, reset                     - clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata          - CPU request, held until cpu_ack
//   cpu_ack, cpu_rdata             - CPU completion pulse and read data
//   dbg_req/we/addr/wdata          - debug request, held until dbg_ack
//   dbg_ack, dbg_rdata             - debug completion pulse and read data
//   grant                          - one-hot owner of the current access
//   busy                           - high whenever the FSM is not idle
//   mem_rdata                      - memory read data
//   mem_addr, mem_wdata            - memory address and write data
//   mem_mem_ena, mem_wr_ena        - memory strobe and write enable
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 16,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_ack,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic                  dbg_ack,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic [1:0]            grant,
  output logic                  busy,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_mem_ena,
  output logic                  mem_wr_ena
);

  state_e                state_q, state_d;
  logic [1:0]            grant_q, grant_d;
  logic                  last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [1:0]            req;
  logic [1:0]            pick;
  logic                  issue;
  logic                  done;
  logic                  capture;

  assign req = {dbg_req, cpu_req};

  mem_arb_rr u_rr (
    .req_i        (req),
    .last_grant_i (last_grant_q),
    .pick_o       (pick)
  );

  // State and transaction registers. last_grant resets to the debug port so
  // the CPU wins the first contention after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= 2'b00;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      cnt_q        <= cnt_d;
    end
  end

  // Next-state logic. The winner's request is latched at grant time, so the
  // memory side only ever sees registered values.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick != 2'b00) begin
          grant_d      = pick;
          last_grant_d = pick[PORT_DBG];
          addr_d       = pick[PORT_DBG] ? dbg_addr  : cpu_addr;
          wdata_d      = pick[PORT_DBG] ? dbg_wdata : cpu_wdata;
          we_d         = pick[PORT_DBG] ? dbg_we    : cpu_we;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CNT_W'(MEM_LATENCY);
        state_d = WAIT;
      end
      WAIT: begin
        // Count reaches 1 in the last of MEM_LATENCY wait cycles.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        grant_d = 2'b00;
        state_d = IDLE;
      end
      default: begin
        grant_d = 2'b00;
        state_d = IDLE;
      end
    endcase
  end

  assign issue   = (state_q == ISSUE);
  assign done    = (state_q == DONE);
  assign capture = (state_q == WAIT) && (cnt_q == CNT_W'(1));

  load_reg #(.WIDTH(DATA_WIDTH)) u_cpu_rdata (
    .clk_i   (clk),
    .reset_i (reset),
    .load_i  (capture & grant_q[PORT_CPU]),
    .d_i     (mem_rdata),
    .q_o     (cpu_rdata)
  );

  load_reg #(.WIDTH(DATA_WIDTH)) u_dbg_rdata (
    .clk_i   (clk),
    .reset_i (reset),
    .load_i  (capture & grant_q[PORT_DBG]),
    .d_i     (mem_rdata),
    .q_o     (dbg_rdata)
  );

  assign grant       = grant_q;
  assign busy        = (state_q != IDLE);
  assign cpu_ack     = done & grant_q[PORT_CPU];
  assign dbg_ack     = done & grant_q[PORT_DBG];
  assign mem_mem_ena = issue;
  assign mem_wr_ena  = issue & we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed vectors, multi-cycle corner cases,
// a MEM_LATENCY=1 instance, and randomized traffic against a transaction model.
module tb_mem_arbiter;

  localparam int LAT  = 2;
  localparam int LAT1 = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [15:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic        cpu_ack, dbg_ack, busy, mem_mem_ena, mem_wr_ena;
  logic [15:0] cpu_rdata, dbg_rdata, mem_rdata, mem_wdata, mem_addr;
  logic [1:0]  grant;

  // Second instance built with a one-cycle memory.
  logic        cpu1_req, cpu1_we, dbg1_req, dbg1_we;
  logic [15:0] cpu1_addr, cpu1_wdata, dbg1_addr, dbg1_wdata;
  logic        cpu1_ack, dbg1_ack, busy1, mem1_ena, mem1_wr;
  logic [15:0] cpu1_rdata, dbg1_rdata, mem1_wdata, mem1_addr;
  logic [15:0] mem1_rdata;
  logic [1:0]  grant1;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .grant(grant), .busy(busy), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata),
    .mem_addr(mem_addr), .mem_mem_ena(mem_mem_ena), .mem_wr_ena(mem_wr_ena)
  );

  mem_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .MEM_LATENCY(LAT1)) dut1 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu1_req), .cpu_we(cpu1_we), .cpu_addr(cpu1_addr), .cpu_wdata(cpu1_wdata),
    .cpu_ack(cpu1_ack), .cpu_rdata(cpu1_rdata),
    .dbg_req(dbg1_req), .dbg_we(dbg1_we), .dbg_addr(dbg1_addr), .dbg_wdata(dbg1_wdata),
    .dbg_ack(dbg1_ack), .dbg_rdata(dbg1_rdata),
    .grant(grant1), .busy(busy1), .mem_rdata(mem1_rdata), .mem_wdata(mem1_wdata),
    .mem_addr(mem1_addr), .mem_mem_ena(mem1_ena), .mem_wr_ena(mem1_wr)
  );

  // Memory device: data appears exactly LAT cycles after the strobe cycle,
  // random garbage otherwise so mistimed captures show up.
  logic [15:0] devMem [256];
  logic [15:0] rdPipe [LAT];
  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) rdPipe[i] <= rdPipe[i-1];
    rdPipe[0] <= mem_mem_ena ? devMem[mem_addr[7:0]] : 16'($urandom);
    if (mem_mem_ena && mem_wr_ena) devMem[mem_addr[7:0]] = mem_wdata;
  end
  assign mem_rdata = rdPipe[LAT-1];

  // One-cycle memory for the second instance; read data is derived from the address.
  always @(posedge clk) mem1_rdata <= mem1_ena ? (mem1_addr ^ 16'h5A5A) : 16'($urandom);

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic setPort(input int p, input logic r, input logic w,
                         input logic [15:0] a, input logic [15:0] d);
    if (p == 0) begin
      cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wdata = d;
    end else begin
      dbg_req = r; dbg_we = w; dbg_addr = a; dbg_wdata = d;
    end
  endtask

  function automatic logic portAck(input int p);
    return (p == 0) ? cpu_ack : dbg_ack;
  endfunction

  function automatic logic [15:0] portRdata(input int p);
    return (p == 0) ? cpu_rdata : dbg_rdata;
  endfunction

  function automatic logic portReq(input int p);
    return (p == 0) ? cpu_req : dbg_req;
  endfunction

  task automatic resetPulse();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  // Directed single-access vectors.
  typedef struct {
    int          port;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    bit          preload;
    logic [15:0] memData;
    logic        expWr;
    logic [15:0] expRdata;
  } vec_t;

  vec_t        vecs [6];
  logic [15:0] holdVal [2];
  bit          holdValid [2];

  task automatic applyStimulus(input vec_t v);
    int t0, strobes, sCyc, aCyc, otherAcks, other;
    logic [15:0] sAddr, sWdata, rd;
    logic sWr;
    bit got;
    other = (v.port == 0) ? 1 : 0;
    if (v.preload) devMem[v.addr[7:0]] = v.memData;
    @(posedge clk); #1;
    setPort(v.port, 1'b1, v.we, v.addr, v.wdata);
    t0 = cyc;
    strobes = 0; otherAcks = 0; got = 0; sCyc = -1; aCyc = -1;
    sAddr = '0; sWdata = '0; sWr = 1'b0; rd = '0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (mem_mem_ena) begin
        strobes++; sCyc = cyc; sAddr = mem_addr; sWr = mem_wr_ena; sWdata = mem_wdata;
      end
      if (portAck(other)) otherAcks++;
      if (portAck(v.port)) begin got = 1; aCyc = cyc; rd = portRdata(v.port); end
    end
    @(posedge clk); #1;
    setPort(v.port, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    if (mem_mem_ena) strobes++;
    checkOutput("ack seen", 32'(got), 32'd1);
    checkOutput("strobe count", 32'(strobes), 32'd1);
    checkOutput("strobe cycle", 32'(sCyc - t0), 32'd1);
    checkOutput("ack latency", 32'(aCyc - t0), 32'(LAT + 2));
    checkOutput("strobe addr", 32'(sAddr), 32'(v.addr));
    checkOutput("strobe wr_ena", 32'(sWr), 32'(v.expWr));
    if (v.we) checkOutput("strobe wdata", 32'(sWdata), 32'(v.wdata));
    else      checkOutput("ack rdata", 32'(rd), 32'(v.expRdata));
    checkOutput("other port ack", 32'(otherAcks), 32'd0);
    if (holdValid[other]) checkOutput("other rdata held", 32'(portRdata(other)), 32'(holdVal[other]));
    holdValid[v.port] = !v.we;
    holdVal[v.port]   = v.expRdata;
  endtask

  // Transaction-level reference model for randomized traffic.
  bit          modelOn = 0;
  bit          active, lastW, gPort, gWe;
  int          gStart;
  logic [15:0] gAddr, gWdata, expData;
  logic [15:0] refMem [256];
  logic [15:0] mVal [2];
  bit          mValid [2];
  bit          ackSeen [2];
  int          rndAcks = 0;

  always @(negedge clk) begin
    if (modelOn) begin
      bit inTxn;
      int n;
      n = cyc;
      inTxn = active && (n >= gStart) && (n <= gStart + LAT + 1);
      checkOutput("rnd grant", 32'(grant), inTxn ? (gPort ? 32'd2 : 32'd1) : 32'd0);
      checkOutput("rnd busy", 32'(busy), 32'(inTxn));
      checkOutput("rnd strobe", 32'(mem_mem_ena), 32'(inTxn && n == gStart));
      if (inTxn && n == gStart) begin
        checkOutput("rnd addr", 32'(mem_addr), 32'(gAddr));
        checkOutput("rnd wr_ena", 32'(mem_wr_ena), 32'(gWe));
        if (gWe) checkOutput("rnd wdata", 32'(mem_wdata), 32'(gWdata));
      end
      for (int p = 0; p < 2; p++) begin
        bit expAck;
        expAck = inTxn && (n == gStart + LAT + 1) && (int'(gPort) == p);
        checkOutput(p == 0 ? "rnd cpu_ack" : "rnd dbg_ack", 32'(portAck(p)), 32'(expAck));
        if (expAck) begin
          rndAcks++;
          if (!gWe) begin
            mValid[p] = 1;
            mVal[p]   = expData;
          end
        end
        if (mValid[p]) checkOutput(p == 0 ? "rnd cpu_rdata" : "rnd dbg_rdata",
                                   32'(portRdata(p)), 32'(mVal[p]));
        ackSeen[p] = portAck(p);
      end
      if (inTxn && n == gStart + LAT + 1) active = 0;
      if (!inTxn && (cpu_req || dbg_req)) begin
        gPort  = (cpu_req && dbg_req) ? !lastW : dbg_req;
        lastW  = gPort;
        gStart = n + 1;
        active = 1;
        gWe    = gPort ? dbg_we : cpu_we;
        gAddr  = gPort ? dbg_addr : cpu_addr;
        gWdata = gPort ? dbg_wdata : cpu_wdata;
        if (gWe) refMem[gAddr[7:0]] = gWdata;
        else     expData = refMem[gAddr[7:0]];
        mValid[gPort] = 0;
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL global timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    int cnt;
    int n;
    int gc [4];
    logic [1:0] gv [4];
    logic [1:0] prevG;
    int ackc [4];
    int t0;
    bit got;

    reset = 1'b1;
    setPort(0, 1'b0, 1'b0, 16'h0, 16'h0);
    setPort(1, 1'b0, 1'b0, 16'h0, 16'h0);
    cpu1_req = 0; cpu1_we = 0; cpu1_addr = '0; cpu1_wdata = '0;
    dbg1_req = 0; dbg1_we = 0; dbg1_addr = '0; dbg1_wdata = '0;

    vecs[0] = '{port:0, we:0, addr:16'h0010, wdata:16'h0000, preload:1, memData:16'hBEEF, expWr:0, expRdata:16'hBEEF};
    vecs[1] = '{port:1, we:1, addr:16'h0200, wdata:16'h1234, preload:0, memData:16'h0000, expWr:1, expRdata:16'h0000};
    vecs[2] = '{port:1, we:0, addr:16'h0200, wdata:16'h0000, preload:0, memData:16'h0000, expWr:0, expRdata:16'h1234};
    vecs[3] = '{port:0, we:1, addr:16'hFFFF, wdata:16'hA5A5, preload:0, memData:16'h0000, expWr:1, expRdata:16'h0000};
    vecs[4] = '{port:0, we:0, addr:16'hFFFF, wdata:16'h0000, preload:0, memData:16'h0000, expWr:0, expRdata:16'hA5A5};
    vecs[5] = '{port:1, we:0, addr:16'h0010, wdata:16'h0000, preload:0, memData:16'h0000, expWr:0, expRdata:16'hBEEF};

    // Reset and idle.
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("reset grant", 32'(grant), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset mem_ena", 32'(mem_mem_ena), 32'd0);
    checkOutput("reset wr_ena", 32'(mem_wr_ena), 32'd0);
    checkOutput("reset mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("reset cpu_rdata", 32'(cpu_rdata), 32'd0);
    checkOutput("reset dbg_rdata", 32'(dbg_rdata), 32'd0);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (cpu_ack || dbg_ack || busy || mem_mem_ena) cnt++;
    end
    checkOutput("idle activity", 32'(cnt), 32'd0);
    holdVal[0] = '0; holdVal[1] = '0; holdValid[0] = 1; holdValid[1] = 1;

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

    // Reset while a CPU read sits in WAIT.
    @(posedge clk); #1;
    setPort(0, 1'b1, 1'b0, 16'h0010, 16'h7777);
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (mem_mem_ena) got = 1;
    end
    checkOutput("mid-reset strobe seen", 32'(got), 32'd1);
    @(negedge clk);
    checkOutput("busy in WAIT", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("async reset busy", 32'(busy), 32'd0);
    checkOutput("async reset grant", 32'(grant), 32'd0);
    checkOutput("async reset mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("async reset mem_wdata", 32'(mem_wdata), 32'd0);
    checkOutput("async reset cpu_rdata", 32'(cpu_rdata), 32'd0);
    checkOutput("async reset dbg_rdata", 32'(dbg_rdata), 32'd0);
    setPort(0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(posedge clk); #1 reset = 1'b0;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (cpu_ack) cnt++;
    end
    checkOutput("no ack after reset", 32'(cnt), 32'd0);
    holdVal[0] = '0; holdVal[1] = '0;
    applyStimulus(vecs[0]);

    // Simultaneous requests held continuously.
    resetPulse();
    @(posedge clk); #1;
    setPort(0, 1'b1, 1'b0, 16'h0030, 16'h0);
    setPort(1, 1'b1, 1'b0, 16'h0040, 16'h0);
    n = 0; prevG = 2'b00;
    for (int k = 0; k < 40 && n < 4; k++) begin
      @(negedge clk);
      if (grant != 2'b00 && prevG == 2'b00) begin
        gv[n] = grant; gc[n] = cyc; n++;
      end
      prevG = grant;
    end
    checkOutput("rr grant count", 32'(n), 32'd4);
    checkOutput("rr grant 0", 32'(gv[0]), 32'd1);
    checkOutput("rr grant 1", 32'(gv[1]), 32'd2);
    checkOutput("rr grant 2", 32'(gv[2]), 32'd1);
    checkOutput("rr grant 3", 32'(gv[3]), 32'd2);
    for (int i = 1; i < 4; i++) checkOutput("rr spacing", 32'(gc[i] - gc[i-1]), 32'(LAT + 3));
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (dbg_ack) got = 1;
    end
    checkOutput("rr final dbg_ack", 32'(got), 32'd1);
    @(posedge clk); #1;
    setPort(0, 1'b0, 1'b0, 16'h0, 16'h0);
    setPort(1, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (2) @(negedge clk);
    checkOutput("rr idle after drop", 32'(busy), 32'd0);

    // MEM_LATENCY=1 instance: single read then back-to-back reads.
    @(posedge clk); #1;
    cpu1_req = 1; cpu1_we = 0; cpu1_addr = 16'h0100;
    t0 = cyc;
    for (int i = 0; i < 4; i++) begin
      got = 0; ackc[i] = -100;
      for (int k = 0; k < 10 && !got; k++) begin
        @(negedge clk);
        if (cpu1_ack) begin
          got = 1; ackc[i] = cyc;
          checkOutput("lat1 rdata", 32'(cpu1_rdata), 32'(cpu1_addr ^ 16'h5A5A));
        end
      end
      checkOutput("lat1 ack seen", 32'(got), 32'd1);
      @(posedge clk); #1;
      if (i < 3) cpu1_addr = cpu1_addr + 16'h0011;
      else       cpu1_req = 0;
    end
    checkOutput("lat1 latency", 32'(ackc[0] - t0), 32'(LAT1 + 2));
    for (int i = 1; i < 4; i++) checkOutput("lat1 spacing", 32'(ackc[i] - ackc[i-1]), 32'(LAT1 + 3));

    // Randomized traffic from both ports.
    for (int i = 0; i < 256; i++) begin
      devMem[i] = 16'($urandom);
      refMem[i] = devMem[i];
    end
    resetPulse();
    active = 0; lastW = 1; gStart = 0;
    mVal[0] = '0; mVal[1] = '0; mValid[0] = 1; mValid[1] = 1;
    ackSeen[0] = 0; ackSeen[1] = 0;
    modelOn = 1;
    for (int c = 0; c < 800; c++) begin
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
        if (ackSeen[p]) begin
          if ($urandom_range(0, 1) == 1)
            setPort(p, 1'b1, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), 16'($urandom));
          else
            setPort(p, 1'b0, 1'b0, 16'h0, 16'h0);
        end else if (!portReq(p) && $urandom_range(0, 2) == 0) begin
          setPort(p, 1'b1, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), 16'($urandom));
        end
      end
    end
    @(negedge clk);
    modelOn = 0;
    checkOutput("rnd enough acks", 32'(rndAcks > 30), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
